// File: rtl/sar_magnitude_search.sv
// sar_magnitude_search
// Drives the B side of a combinational magnitude comparator. It recovers the
// unknown value on the comparator's A input by successive approximation:
// MSB first, one trial bit per clock, and it stops early when the comparator
// reports equality.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset (priority over everything)
//   start    begin a search; only looked at while idle
//   A_gt_B   comparator flag: unknown A > trial
//   A_lt_B   comparator flag: unknown A < trial
//   A_eq_B   comparator flag: unknown A == trial
//   trial    registered value presented to the comparator B input
//   result   recovered value, held from done until the next start
//   busy     high while trial bits are being tested
//   done     one-cycle pulse when result is valid
//   err      raised with done when the flags were inconsistent; held until next start
module sar_magnitude_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             A_gt_B,
  input  logic             A_lt_B,
  input  logic             A_eq_B,
  output logic [WIDTH-1:0] trial,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] nextTrial;
  logic             flagsOneHot;

  // State and output registers. busy/done are registered from the next state
  // so every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      trial_q  <= '0;
      result_q <= '0;
      idx_q    <= IDX_TOP;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic. In TEST the flags describe the trial registered during
  // this cycle; the current bit is kept on "greater" and cleared on "less",
  // then the next lower bit is set as the new guess.
  always_comb begin
    state_d     = state_q;
    trial_d     = trial_q;
    result_d    = result_q;
    idx_d       = idx_q;
    err_d       = err_q;
    nextTrial   = trial_q;
    flagsOneHot = ({A_gt_B, A_lt_B, A_eq_B} == 3'b100) ||
                  ({A_gt_B, A_lt_B, A_eq_B} == 3'b010) ||
                  ({A_gt_B, A_lt_B, A_eq_B} == 3'b001);

    case (state_q)
      IDLE: begin
        if (start) begin
          trial_d            = '0;
          trial_d[WIDTH-1]   = 1'b1;
          idx_d              = IDX_TOP;
          result_d           = '0;
          err_d              = 1'b0;
          state_d            = TEST;
        end
      end

      TEST: begin
        if (!flagsOneHot) begin
          err_d    = 1'b1;
          result_d = trial_q;
          state_d  = DONE;
        end else if (A_eq_B) begin
          result_d = trial_q;
          state_d  = DONE;
        end else if (A_gt_B && (idx_q == '0)) begin
          // Every bit is already set as far as it can go; a consistent
          // comparator cannot report "greater" here.
          err_d    = 1'b1;
          result_d = trial_q;
          state_d  = DONE;
        end else begin
          if (A_lt_B) begin
            nextTrial[idx_q] = 1'b0;
          end
          if (idx_q == '0) begin
            result_d = nextTrial;
            state_d  = DONE;
          end else begin
            trial_d                  = nextTrial;
            trial_d[idx_q - IDX_ONE] = 1'b1;
            idx_d                    = idx_q - IDX_ONE;
          end
        end
      end

      DONE: begin
        // trial keeps its last value during DONE and returns to zero in IDLE.
        trial_d = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == TEST);
    done_d = (state_d == DONE);
  end

  assign trial  = trial_q;
  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_magnitude_search.sv
// tb_sar_magnitude_search
// Directed bench for sar_magnitude_search at WIDTH=4. A small comparator model
// compares a stored unknown A against the DUT's trial output, with optional
// overrides that corrupt the flags at a chosen trial value.
module tb_sar_magnitude_search;

  logic       clk;
  logic       reset;
  logic       start;
  logic       gtF, ltF, eqF;
  logic [3:0] trial;
  logic [3:0] result;
  logic       busy;
  logic       done;
  logic       err;

  logic [3:0] aVal;
  int         forceMode;
  logic [3:0] forceTrial;

  int compared;
  int mismatched;

  // Observations gathered by doSearch.
  logic [3:0] seq [8];
  int         nTrials;
  int         busyCnt;
  int         doneCycle;
  int         donePulses;
  logic [3:0] resAtDone;
  logic       errAtDone;
  logic [3:0] trialAtDone;
  logic [3:0] resAfter;
  logic       errAfter;
  logic [3:0] trialAfter;

  sar_magnitude_search #(.WIDTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .A_gt_B (gtF),
    .A_lt_B (ltF),
    .A_eq_B (eqF),
    .trial  (trial),
    .result (result),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model with optional flag corruption at one trial value.
  always_comb begin
    gtF = (aVal > trial);
    ltF = (aVal < trial);
    eqF = (aVal == trial);
    if (forceMode == 1 && trial == forceTrial) begin
      {gtF, ltF, eqF} = 3'b000;
    end else if (forceMode == 2 && trial == forceTrial) begin
      {gtF, ltF, eqF} = 3'b100;
    end
  end

  // Pulses start for one sampling edge (E), then watches 12 cycles, recording
  // trials while busy and the state around the first done pulse. Cycle k is the
  // cycle following edge E+k-1. A second start is raised in cycle restartAt.
  task automatic doSearch(input logic [3:0] a, input int restartAt);
    aVal       = a;
    nTrials    = 0;
    busyCnt    = 0;
    doneCycle  = 0;
    donePulses = 0;
    resAtDone  = 'x;
    errAtDone  = 1'bx;
    trialAtDone = 'x;
    resAfter   = 'x;
    errAfter   = 1'bx;
    trialAfter = 'x;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = (k == restartAt);
      if (busy === 1'b1) begin
        if (nTrials < 8) seq[nTrials] = trial;
        nTrials++;
        busyCnt++;
      end
      if (done === 1'b1) begin
        donePulses++;
        if (doneCycle == 0) begin
          doneCycle   = k;
          resAtDone   = result;
          errAtDone   = err;
          trialAtDone = trial;
        end
      end
      if (doneCycle != 0 && k == doneCycle + 1) begin
        resAfter   = result;
        errAfter   = err;
        trialAfter = trial;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++;
    if ({trial, result, busy, done, err} !== 11'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %b, expected %b", {trial, result, busy, done, err}, 11'd0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if (busy !== 1'b0 || trial !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL idle_after_reset: got busy=%b trial=%0d, expected busy=0 trial=0", busy, trial);
    end
  endtask

  task automatic test_sequences();
    logic [3:0] aTab   [4];
    logic [3:0] expSeq [4][4];
    aTab = '{4'd5, 4'd0, 4'd15, 4'd9};
    expSeq[0] = '{4'd8, 4'd4, 4'd6, 4'd5};
    expSeq[1] = '{4'd8, 4'd4, 4'd2, 4'd1};
    expSeq[2] = '{4'd8, 4'd12, 4'd14, 4'd15};
    expSeq[3] = '{4'd8, 4'd12, 4'd10, 4'd9};
    for (int c = 0; c < 4; c++) begin
      doSearch(aTab[c], 0);
      compared++;
      if (nTrials != 4) begin
        mismatched++;
        $display("[TB] FAIL seq_len A=%0d: got %0d, expected 4", aTab[c], nTrials);
      end
      for (int i = 0; i < 4; i++) begin
        compared++;
        if (seq[i] !== expSeq[c][i]) begin
          mismatched++;
          $display("[TB] FAIL seq A=%0d step %0d: got %0d, expected %0d", aTab[c], i, seq[i], expSeq[c][i]);
        end
      end
      compared++;
      if (doneCycle != 5 || donePulses != 1) begin
        mismatched++;
        $display("[TB] FAIL done_timing A=%0d: got cycle %0d pulses %0d, expected cycle 5 pulses 1", aTab[c], doneCycle, donePulses);
      end
      compared++;
      if (resAtDone !== aTab[c] || errAtDone !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL result A=%0d: got %0d err=%b, expected %0d err=0", aTab[c], resAtDone, errAtDone, aTab[c]);
      end
      compared++;
      if (trialAtDone !== expSeq[c][3] || trialAfter !== 4'd0 || resAfter !== aTab[c]) begin
        mismatched++;
        $display("[TB] FAIL hold A=%0d: got trialAtDone=%0d trialAfter=%0d resAfter=%0d, expected %0d 0 %0d", aTab[c], trialAtDone, trialAfter, resAfter, expSeq[c][3], aTab[c]);
      end
    end
  endtask

  task automatic test_early_exit();
    doSearch(4'd8, 0);
    compared++;
    if (doneCycle != 2) begin
      mismatched++;
      $display("[TB] FAIL early_done_cycle: got %0d, expected 2", doneCycle);
    end
    compared++;
    if (busyCnt != 1) begin
      mismatched++;
      $display("[TB] FAIL early_busy_cycles: got %0d, expected 1", busyCnt);
    end
    compared++;
    if (resAtDone !== 4'd8 || errAtDone !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL early_result: got %0d err=%b, expected 8 err=0", resAtDone, errAtDone);
    end
  endtask

  task automatic test_error_flags();
    forceMode  = 1;
    forceTrial = 4'd4;
    doSearch(4'd5, 0);
    compared++;
    if (doneCycle != 3 || nTrials != 2) begin
      mismatched++;
      $display("[TB] FAIL noflags_timing: got cycle %0d trials %0d, expected cycle 3 trials 2", doneCycle, nTrials);
    end
    compared++;
    if (errAtDone !== 1'b1 || resAtDone !== 4'd4) begin
      mismatched++;
      $display("[TB] FAIL noflags_err: got err=%b result=%0d, expected err=1 result=4", errAtDone, resAtDone);
    end
    compared++;
    if (errAfter !== 1'b1 || resAfter !== 4'd4) begin
      mismatched++;
      $display("[TB] FAIL noflags_hold: got err=%b result=%0d, expected err=1 result=4", errAfter, resAfter);
    end
    forceMode  = 2;
    forceTrial = 4'd5;
    doSearch(4'd5, 0);
    compared++;
    if (doneCycle != 5 || errAtDone !== 1'b1 || resAtDone !== 4'd5) begin
      mismatched++;
      $display("[TB] FAIL gt_at_lsb: got cycle %0d err=%b result=%0d, expected cycle 5 err=1 result=5", doneCycle, errAtDone, resAtDone);
    end
    forceMode = 0;
    doSearch(4'd3, 0);
    compared++;
    if (errAtDone !== 1'b0 || resAtDone !== 4'd3) begin
      mismatched++;
      $display("[TB] FAIL err_cleared: got err=%b result=%0d, expected err=0 result=3", errAtDone, resAtDone);
    end
  endtask

  task automatic test_reset_mid_search();
    aVal = 4'd5;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    compared++;
    if (trial !== 4'd4 || busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midsearch_trial: got trial=%0d busy=%b, expected trial=4 busy=1", trial, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if ({trial, result, busy, done, err} !== 11'd0) begin
      mismatched++;
      $display("[TB] FAIL midsearch_reset: got %b, expected %b", {trial, result, busy, done, err}, 11'd0);
    end
    reset = 1'b0;
    donePulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) donePulses++;
    end
    compared++;
    if (donePulses != 0) begin
      mismatched++;
      $display("[TB] FAIL midsearch_stays_idle: got %0d active cycles, expected 0", donePulses);
    end
  endtask

  task automatic test_start_ignored();
    logic [3:0] expSeq [4];
    expSeq = '{4'd8, 4'd4, 4'd6, 4'd5};
    doSearch(4'd5, 2);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (seq[i] !== expSeq[i]) begin
        mismatched++;
        $display("[TB] FAIL busy_restart seq step %0d: got %0d, expected %0d", i, seq[i], expSeq[i]);
      end
    end
    compared++;
    if (donePulses != 1 || nTrials != 4 || doneCycle != 5) begin
      mismatched++;
      $display("[TB] FAIL busy_restart_done: got pulses %0d trials %0d cycle %0d, expected 1 4 5", donePulses, nTrials, doneCycle);
    end
    doSearch(4'd5, 5);
    compared++;
    if (donePulses != 1 || busyCnt != 4) begin
      mismatched++;
      $display("[TB] FAIL done_restart: got pulses %0d busy %0d, expected 1 4", donePulses, busyCnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] doneMask;
    logic [8:0] busyMask;
    aVal     = 4'd8;
    doneMask = '0;
    busyMask = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) doneMask[k] = 1'b1;
      if (busy === 1'b1) busyMask[k] = 1'b1;
    end
    start = 1'b0;
    compared++;
    if (doneMask !== 9'b1_0010_0100) begin
      mismatched++;
      $display("[TB] FAIL b2b_done: got %b, expected %b", doneMask, 9'b1_0010_0100);
    end
    compared++;
    if (busyMask !== 9'b0_1001_0010) begin
      mismatched++;
      $display("[TB] FAIL b2b_busy: got %b, expected %b", busyMask, 9'b0_1001_0010);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    forceMode  = 0;
    forceTrial = 4'd0;
    aVal       = 4'd0;
    reset      = 1'b1;
    start      = 1'b0;
    test_reset();
    test_sequences();
    test_early_exit();
    test_error_flags();
    test_reset_mid_search();
    test_start_ignored();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
